axis_uart: RTL and testbench
============================

AXIS_UART -- requirements
Module: axis_uart

Interface
REQ-001 The block SHALL have parameter CLOCK, default 100_000_000: aclk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200: UART bit rate in bit/s.
REQ-003 The block SHALL have port aclk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port aresetn, input, 1 bit: reset, synchronous, active-high (1 = reset); one clock, no other clock or reset.
REQ-005 The block SHALL have port uart_rx, input, 1 bit: serial receive line, idle high, asynchronous to aclk.
REQ-006 The block SHALL have port uart_tx, output, 1 bit: serial transmit line, idle high.
REQ-007 The block SHALL have port m_axis, axis_if master modport: tdata[7:0] out, tvalid out, tready in; carries received bytes.
REQ-008 The block SHALL have port s_axis, axis_if slave modport: tdata[7:0] in, tvalid in, tready out; carries bytes to transmit.
REQ-009 axis_if SHALL be a parameterless interface with logic tdata[7:0], tvalid, tready and master/slave modports.

Function
REQ-010 Bit period SHALL be DIV = CLOCK/BAUD_RATE cycles (integer division, elaborated constant); frame format SHALL be 8N1, LSB first.
REQ-011 TX states SHALL be IDLE, START, DATA, STOP; s_axis.tready SHALL be 1 only in IDLE.
REQ-012 A TX transfer SHALL occur on a cycle with s_axis.tvalid && s_axis.tready; tdata SHALL be latched that cycle and uart_tx SHALL drive 0 (start bit) from the next cycle.
REQ-013 TX SHALL hold START 1 bit, DATA bits 0..7 1 bit each, then STOP (1) 1 bit, then return to IDLE; a full frame SHALL last 10*DIV cycles.
REQ-014 s_axis.tvalid without tready SHALL have no effect; back-to-back bytes SHALL be accepted in the IDLE cycle following STOP.
REQ-015 uart_rx SHALL pass through a 2-flop synchronizer before use.
REQ-016 RX states SHALL be IDLE, START, DATA, STOP; a synchronized 1->0 edge in IDLE SHALL enter START.
REQ-017 RX SHALL resample at DIV/2 cycles after the edge; if the line is 1, RX SHALL return to IDLE (glitch rejected).
REQ-018 RX SHALL sample each data bit at DIV cycles after the previous sample (bit centre) and shift LSB first.
REQ-019 At the stop-bit sample: if 1, the byte SHALL be written to the output register; if 0 (framing error), the byte SHALL be discarded; RX SHALL then return to IDLE.
REQ-020 The m_axis output register SHALL be one entry: tvalid set when a byte is written, cleared on a cycle with m_axis.tvalid && m_axis.tready.
REQ-021 m_axis.tdata and tvalid SHALL stay stable while tvalid=1 and tready=0.
REQ-022 tready SHALL be allowed to be high before tvalid; the transfer SHALL occur on the first cycle both are 1.
REQ-023 If a new byte completes while tvalid=1 and no handshake occurs that cycle, the new byte SHALL be dropped (overrun) and the held byte kept.
REQ-024 If a new byte completes on the same cycle as a handshake, the new byte SHALL be loaded and tvalid SHALL stay 1.
REQ-025 TX and RX SHALL operate fully concurrently and independently.

Reset
REQ-026 While aresetn=1: uart_tx=1, s_axis.tready=0, m_axis.tvalid=0, m_axis.tdata=0, both FSMs IDLE, counters 0, synchronizer flops 1.
REQ-027 Reset mid-frame SHALL abort the frame immediately; s_axis.tready SHALL return to 1 on the first cycle after release.

Structure
REQ-028 A shared package SHALL hold the FSM state enums (tx_state_t, rx_state_t) and the DIV computation function.
REQ-029 axis_uart SHALL contain the sub-modules uart_tx and uart_rx; the m_axis output register SHALL be in the top level.

Verification (CLOCK=50_000_000, BAUD_RATE=5_000_000, DIV=10, uart_rx looped to uart_tx)
REQ-030 Send 0xA5 via s_axis -> uart_tx levels 0,1,0,1,0,0,1,0,1,1 for 10 cycles each; m_axis shows 0xA5.
REQ-031 Send 256 random bytes with 0-20 cycle gaps and random tready patterns (held high, one-cycle pulse, delayed pulse) -> all bytes received in order, 0 mismatches.
REQ-032 Hold tready=0 while two bytes complete -> first byte kept stable, second dropped; tready then transfers the first byte only.
REQ-033 Drive uart_rx low for 3 cycles (loop broken) -> no byte produced, RX back in IDLE.
REQ-034 Frame with stop bit 0 -> no m_axis tvalid; next valid frame 0x3C received correctly.
REQ-035 Assert aresetn during DATA of a TX frame -> uart_tx=1 next cycle, s_axis.tready=1 after release, m_axis.tvalid=0.

Source files
------------

// File: rtl/axis_uart_pkg.sv
// Shared types and helpers for the AXI-Stream UART: TX/RX FSM states and the bit-period divider.
// Latency: none (types and elaboration-time constants only).
// Backpressure: none.
package axis_uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Clock cycles per UART bit. Integer division, so the real baud rate is
  // rounded up slightly when CLOCK is not an exact multiple of BAUD_RATE.
  function automatic int unsigned calc_div(input int unsigned clock_hz,
                                           input int unsigned baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal byte-wide AXI-Stream channel: tdata/tvalid/tready with master and slave views.
// Latency: none (wires only).
// Backpressure: standard valid/ready; the transfer happens on a cycle where both are high.
interface axis_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: synchronises the line, finds the start edge, samples 8N1 at bit centres.
// Latency: byte_vld_o pulses at the centre of the stop bit (about 9.5 bit periods plus 3 clocks after the line falls).
// Backpressure: none; the caller must take the one-cycle byte_vld_o pulse or lose it.
module uart_rx
  import axis_uart_pkg::*;
#(
  parameter int unsigned DIV = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o
);

  localparam int unsigned   CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          sync1_q, sync2_q, prev_q;
  logic          fall;

  // Falling edge seen on the synchronised line (prev_q is one cycle older than sync2_q).
  assign fall   = prev_q && !sync2_q;
  assign byte_o = shreg_q;

  // Two-flop synchronizer for the asynchronous line plus one history flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // State, sample counter, bit index and shift register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Half-bit check of the start bit, then full-bit steps to each data and stop bit centre.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    byte_vld_o = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          // A line already back high at mid start bit is treated as a glitch.
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          // A low stop bit is a framing error; the byte is silently discarded.
          byte_vld_o = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte as 8N1, LSB first, DIV clocks per bit.
// Latency: start bit on the line the cycle after the accepting handshake; frame lasts 10*DIV cycles.
// Backpressure: tready_o is high only in IDLE, so a new byte is taken in the cycle after the stop bit.
module uart_tx
  import axis_uart_pkg::*;
#(
  parameter int unsigned DIV = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tdata_i,
  input  logic       tvalid_i,
  output logic       tready_o,
  output logic       tx_o
);

  localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end  = (cnt_q == CNT_LAST);
  // Ready is masked during reset so nothing is accepted while the FSM is being cleared.
  assign tready_o = (state_q == TX_IDLE) && !rst_i;
  assign tx_o     = tx_q;

  // State, bit-period counter, shift register and registered line level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  // Frame sequencing: the line level for the next bit is registered one cycle ahead.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (state_q)
      TX_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (tvalid_i && tready_o) begin
          shreg_d = tdata_i;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = shreg_q[0];
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = TX_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/axis_uart.sv
// AXI-Stream UART bridge: s_axis bytes go out on uart_tx, bytes from uart_rx come out on m_axis.
// Latency: TX start bit one cycle after s_axis handshake; RX byte visible one cycle after its stop-bit centre.
// Backpressure: s_axis stalls for a whole frame; m_axis holds one byte and drops newer bytes while it is full.
module axis_uart
  import axis_uart_pkg::*;
#(
  parameter int unsigned CLOCK     = 100_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic   aclk,
  input  logic   aresetn,
  input  logic   uart_rx,
  output logic   uart_tx,
  axis_if.master m_axis,
  axis_if.slave  s_axis
);

  // DIV must be at least 2 so the half-bit start check has a non-zero wait.
  localparam int unsigned DIV = calc_div(CLOCK, BAUD_RATE);

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic [7:0] tdata_q, tdata_d;
  logic       tvalid_q, tvalid_d;
  logic       m_hs;

  uart_tx #(
    .DIV (DIV)
  ) u_tx (
    .clk_i    (aclk),
    .rst_i    (aresetn),
    .tdata_i  (s_axis.tdata),
    .tvalid_i (s_axis.tvalid),
    .tready_o (s_axis.tready),
    .tx_o     (uart_tx)
  );

  uart_rx #(
    .DIV (DIV)
  ) u_rx (
    .clk_i      (aclk),
    .rst_i      (aresetn),
    .rx_i       (uart_rx),
    .byte_o     (rx_byte),
    .byte_vld_o (rx_vld)
  );

  assign m_hs          = tvalid_q && m_axis.tready;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;

  // One-entry output register.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  // Load a new byte when empty or draining this cycle; otherwise the new byte is an overrun and is lost.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    if (rx_vld && (!tvalid_q || m_hs)) begin
      tdata_d  = rx_byte;
      tvalid_d = 1'b1;
    end else if (m_hs) begin
      tvalid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_uart.sv
// Directed bench for axis_uart with uart_tx looped to uart_rx (loop can be broken for hand-driven frames).
// Latency: n/a.
// Backpressure: n/a.
module tb_axis_uart;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned BAUD   = 5_000_000;
  localparam int          DIV    = 10;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic loop_en = 1'b1;
  logic rx_man  = 1'b1;
  logic uart_tx_w;
  logic rx_line;

  int n_chk = 0;
  int n_err = 0;

  // A5 frame levels: start, bits 0..7 LSB first, stop.
  logic lv [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  axis_if m_if ();
  axis_if s_if ();

  always #5 clk = ~clk;

  assign rx_line = loop_en ? uart_tx_w : rx_man;

  axis_uart #(
    .CLOCK     (CLK_HZ),
    .BAUD_RATE (BAUD)
  ) dut (
    .aclk    (clk),
    .aresetn (rst),
    .uart_rx (rx_line),
    .uart_tx (uart_tx_w),
    .m_axis  (m_if),
    .s_axis  (s_if)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for s_axis ready, then present one byte for a single cycle.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    while (s_if.tready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("send_rdy", s_if.tready, 1'b1);
    s_if.tdata  = b;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_mvld(input int budget);
    int t;
    t = 0;
    while (m_if.tvalid !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Hand-drive one 8N1 frame on rx_man; saw reports any m_axis tvalid during the frame.
  task automatic drive_frame(input logic [7:0] b, input logic stop, output logic saw);
    saw    = 1'b0;
    rx_man = 1'b0;
    repeat (DIV) begin @(negedge clk); if (m_if.tvalid === 1'b1) saw = 1'b1; end
    for (int i = 0; i < 8; i++) begin
      rx_man = b[i];
      repeat (DIV) begin @(negedge clk); if (m_if.tvalid === 1'b1) saw = 1'b1; end
    end
    rx_man = stop;
    repeat (DIV) begin @(negedge clk); if (m_if.tvalid === 1'b1) saw = 1'b1; end
    rx_man = 1'b1;
  endtask

  task automatic drain(input string tag);
    m_if.tready = 1'b1;
    @(negedge clk);
    m_if.tready = 1'b0;
    chk(tag, m_if.tvalid, 1'b0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       saw;
    logic       stable;
    logic [7:0] q [$];

    s_if.tdata  = 8'h00;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_tx", uart_tx_w, 1'b1);
    chk("rst_s_tready", s_if.tready, 1'b0);
    chk("rst_m_tvalid", m_if.tvalid, 1'b0);
    chk("rst_m_tdata", m_if.tdata, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_s_tready", s_if.tready, 1'b1);
    chk("idle_tx", uart_tx_w, 1'b1);

    // Single byte 0xA5: exact line levels, busy flag, loopback result
    s_if.tdata  = 8'hA5;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < DIV; c++) begin
        chk($sformatf("a5_bit%0d", b), uart_tx_w, lv[b]);
        if (b == 5 && c == 0) chk("a5_busy_tready", s_if.tready, 1'b0);
        @(negedge clk);
      end
    end
    chk("a5_done_tready", s_if.tready, 1'b1);
    wait_mvld(50);
    chk("a5_vld", m_if.tvalid, 1'b1);
    chk("a5_data", m_if.tdata, 8'hA5);
    drain("a5_drain");

    // 256 random bytes, random gaps, three tready styles
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          logic [7:0] sb;
          sb = 8'($urandom);
          q.push_back(sb);
          send_byte(sb);
          repeat ($urandom_range(0, 20)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 256; i++) begin
          int         mode;
          logic [7:0] exp_b;
          mode = $urandom_range(0, 2);
          if (mode == 0) m_if.tready = 1'b1;
          wait_mvld(400);
          chk("rnd_vld", m_if.tvalid, 1'b1);
          exp_b = 8'h00;
          if (q.size() > 0) exp_b = q.pop_front();
          if (mode == 2) repeat ($urandom_range(1, 5)) @(negedge clk);
          chk($sformatf("rnd_data%0d", i), m_if.tdata, exp_b);
          drain("rnd_drain");
        end
      end
    join

    // Overrun: first byte held stable, second dropped
    send_byte(8'h11);
    send_byte(8'h22);
    wait_mvld(200);
    chk("ovr_vld", m_if.tvalid, 1'b1);
    chk("ovr_first", m_if.tdata, 8'h11);
    stable = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== 8'h11) stable = 1'b0;
    end
    chk("ovr_stable", stable, 1'b1);
    drain("ovr_drain");
    repeat (120) @(negedge clk);
    chk("ovr_no_second", m_if.tvalid, 1'b0);

    // Three-cycle glitch rejected, receiver still usable
    loop_en = 1'b0;
    rx_man  = 1'b1;
    repeat (5) @(negedge clk);
    rx_man = 1'b0;
    repeat (3) @(negedge clk);
    rx_man = 1'b1;
    saw = 1'b0;
    repeat (150) begin @(negedge clk); if (m_if.tvalid === 1'b1) saw = 1'b1; end
    chk("glitch_none", saw, 1'b0);
    drive_frame(8'h5A, 1'b1, saw);
    wait_mvld(40);
    chk("glitch_next_vld", m_if.tvalid, 1'b1);
    chk("glitch_next_data", m_if.tdata, 8'h5A);
    drain("glitch_drain");

    // Framing error discarded, next good frame 0x3C received
    repeat (20) @(negedge clk);
    drive_frame(8'h96, 1'b0, saw);
    repeat (30) begin @(negedge clk); if (m_if.tvalid === 1'b1) saw = 1'b1; end
    chk("ferr_none", saw, 1'b0);
    drive_frame(8'h3C, 1'b1, saw);
    wait_mvld(40);
    chk("ferr_next_vld", m_if.tvalid, 1'b1);
    chk("ferr_next_data", m_if.tdata, 8'h3C);
    drain("ferr_drain");

    // Reset in the middle of a TX data bit, with a byte held on m_axis
    repeat (20) @(negedge clk);
    drive_frame(8'h77, 1'b1, saw);
    wait_mvld(40);
    chk("prerst_vld", m_if.tvalid, 1'b1);
    repeat (20) @(negedge clk);
    loop_en = 1'b1;
    send_byte(8'hC3);
    repeat (34) @(negedge clk);
    chk("prerst_tx_bit2", uart_tx_w, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_tx", uart_tx_w, 1'b1);
    chk("rstmid_s_tready", s_if.tready, 1'b0);
    chk("rstmid_m_tvalid", m_if.tvalid, 1'b0);
    chk("rstmid_m_tdata", m_if.tdata, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("rstrel_s_tready", s_if.tready, 1'b1);
    chk("rstrel_tx", uart_tx_w, 1'b1);
    saw = 1'b0;
    repeat (150) begin @(negedge clk); if (m_if.tvalid === 1'b1) saw = 1'b1; end
    chk("rstrel_no_rx", saw, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
